// File: rtl/ship_laser_gen.sv
// rtl/ship_laser_gen.sv - player ship position and single-laser generator for the video pipeline
//
// Moves a ship left/right and launches one laser upward from its centre. All
// movement happens on the frame tick (y==481, x==0), i.e. once per frame
// during vertical blanking, so the picture never tears mid-frame.
//
// Build option: define LASER_AUTOFIRE_EN to relaunch continuously while the
// fire button is held; without it only fresh presses of fire are accepted.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   x, y         current pixel column / row from the video timing generator
//   btn_left     raw asynchronous button, move ship left
//   btn_right    raw asynchronous button, move ship right
//   btn_fire     raw asynchronous button, launch laser
//   laser_hit    collision report from the alien stage (honoured only in flight)
//   ship_x       ship left column
//   laser_top    laser bounds; all four park at 1023 when no laser is in flight
//   laser_bot
//   laser_left
//   laser_right
//   ship_on      current pixel lies inside the ship
//   laser_on     current pixel lies inside the flying laser
module ship_laser_gen #(
    parameter int SHIP_Y_TOP      = 450,
    parameter int SHIP_W          = 40,
    parameter int SHIP_H          = 10,
    parameter int LASER_W         = 4,
    parameter int LASER_H         = 12,
    parameter int LASER_SPEED     = 4,
    parameter int SHIP_SPEED      = 2,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       laser_hit,
    output logic [9:0] ship_x,
    output logic [9:0] laser_top,
    output logic [9:0] laser_bot,
    output logic [9:0] laser_left,
    output logic [9:0] laser_right,
    output logic       ship_on,
    output logic       laser_on
);

    // All geometry is carried in 10 bits; the movement guards keep every
    // result inside 0..1023 so nothing wraps.
    localparam logic [9:0] SHIP_Y0    = 10'(SHIP_Y_TOP);
    localparam logic [9:0] SHIP_W10   = 10'(SHIP_W);
    localparam logic [9:0] SHIP_H10   = 10'(SHIP_H);
    localparam logic [9:0] LASER_W10  = 10'(LASER_W);
    localparam logic [9:0] LASER_H10  = 10'(LASER_H);
    localparam logic [9:0] LASER_SPD  = 10'(LASER_SPEED);
    localparam logic [9:0] SHIP_SPD   = 10'(SHIP_SPEED);
    localparam logic [9:0] COOL_LOAD  = 10'(COOLDOWN_FRAMES);
    localparam logic [9:0] LAUNCH_OFS = 10'((SHIP_W - LASER_W) / 2);
    localparam logic [9:0] LAUNCH_TOP = 10'(SHIP_Y_TOP - LASER_H);
    localparam logic [9:0] SHIP_X_RST = 10'd300;
    localparam logic [9:0] X_LAST     = 10'd639;
    localparam logic [9:0] PARK       = 10'd1023;
    localparam logic [9:0] TICK_ROW   = 10'd481;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_COOL = 2'd2
    } state_t;

    // Button synchronisers, bit order {fire, right, left}.
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       fire_prev_q;

    logic       left_s;
    logic       right_s;
    logic       fire_s;
    logic       fire_rise;
    logic       frame_tick;

    state_t     state_q, state_d;
    logic [9:0] ship_x_q, ship_x_d;
    logic [9:0] laser_top_q, laser_top_d;
    logic [9:0] laser_left_q, laser_left_d;
    logic [9:0] cool_cnt_q, cool_cnt_d;
    logic       fire_pending_q, fire_pending_d;
    logic       launch;
    logic       in_fly;

    assign left_s     = sync2_q[0];
    assign right_s    = sync2_q[1];
    assign fire_s     = sync2_q[2];
    assign fire_rise  = fire_s & ~fire_prev_q;
    assign frame_tick = (y == TICK_ROW) && (x == 10'd0);

    // ------------------------------------------------------------------
    // Ship movement: one step per frame, held at the screen edges and when
    // both or neither direction is pressed.
    // ------------------------------------------------------------------
    always_comb begin
        ship_x_d = ship_x_q;
        if (frame_tick) begin
            if (left_s && !right_s) begin
                if (ship_x_q >= SHIP_SPD) begin
                    ship_x_d = ship_x_q - SHIP_SPD;
                end
            end else if (right_s && !left_s) begin
                if ((ship_x_q + SHIP_W10 - 10'd1 + SHIP_SPD) <= X_LAST) begin
                    ship_x_d = ship_x_q + SHIP_SPD;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Laser state machine. The launch column is taken from the registered
    // ship_x, i.e. the position before this tick's ship move.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        laser_top_d  = laser_top_q;
        laser_left_d = laser_left_q;
        cool_cnt_d   = cool_cnt_q;
        launch       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_tick && fire_pending_q) begin
                    state_d      = S_FLY;
                    launch       = 1'b1;
                    laser_left_d = ship_x_q + LAUNCH_OFS;
                    laser_top_d  = LAUNCH_TOP;
                end
            end
            S_FLY: begin
                // A hit wins over a coincident tick: the laser is not moved.
                if (laser_hit) begin
                    state_d    = S_COOL;
                    cool_cnt_d = COOL_LOAD;
                end else if (frame_tick) begin
                    if (laser_top_q < LASER_SPD) begin
                        state_d    = S_COOL;
                        cool_cnt_d = COOL_LOAD;
                    end else begin
                        laser_top_d = laser_top_q - LASER_SPD;
                    end
                end
            end
            S_COOL: begin
                if (frame_tick) begin
                    // <= rather than == so a zero-length cooldown cannot wrap.
                    if (cool_cnt_q <= 10'd1) begin
                        state_d    = S_IDLE;
                        cool_cnt_d = 10'd0;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 10'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A new press that lands on the launch cycle stays pending for the next
    // flight; presses during flight or cooldown are remembered too.
    always_comb begin
        fire_pending_d = (fire_pending_q & ~launch) | fire_rise;
`ifdef LASER_AUTOFIRE_EN
        if (frame_tick && fire_s) begin
            fire_pending_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= 3'b000;
            sync2_q        <= 3'b000;
            fire_prev_q    <= 1'b0;
            state_q        <= S_IDLE;
            ship_x_q       <= SHIP_X_RST;
            laser_top_q    <= PARK;
            laser_left_q   <= PARK;
            cool_cnt_q     <= 10'd0;
            fire_pending_q <= 1'b0;
        end else begin
            sync1_q        <= {btn_fire, btn_right, btn_left};
            sync2_q        <= sync1_q;
            fire_prev_q    <= fire_s;
            state_q        <= state_d;
            ship_x_q       <= ship_x_d;
            laser_top_q    <= laser_top_d;
            laser_left_q   <= laser_left_d;
            cool_cnt_q     <= cool_cnt_d;
            fire_pending_q <= fire_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Outside flight the bounds park at 1023, which lies beyond
    // any visible pixel, so the alien stage can never see a collision.
    // ------------------------------------------------------------------
    assign in_fly      = (state_q == S_FLY);
    assign ship_x      = ship_x_q;
    assign laser_top   = in_fly ? laser_top_q : PARK;
    assign laser_left  = in_fly ? laser_left_q : PARK;
    assign laser_bot   = in_fly ? (laser_top_q + LASER_H10 - 10'd1) : PARK;
    assign laser_right = in_fly ? (laser_left_q + LASER_W10 - 10'd1) : PARK;

    assign ship_on = (y >= SHIP_Y0) && (y <= (SHIP_Y0 + SHIP_H10 - 10'd1)) &&
                     (x >= ship_x_q) && (x <= (ship_x_q + SHIP_W10 - 10'd1));

    assign laser_on = in_fly &&
                      (x >= laser_left_q) &&
                      (x <= (laser_left_q + LASER_W10 - 10'd1)) &&
                      (y >= laser_top_q) &&
                      (y <= (laser_top_q + LASER_H10 - 10'd1));

endmodule

// File: tb/tb_ship_laser_gen.sv
// tb/tb_ship_laser_gen.sv - self-checking bench for ship_laser_gen
module tb_ship_laser_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = 10'd700;
    logic [9:0] y = 10'd0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_fire = 1'b0;
    logic       laser_hit = 1'b0;
    logic [9:0] ship_x, laser_top, laser_bot, laser_left, laser_right;
    logic       ship_on, laser_on;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ship_laser_gen dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_fire(btn_fire),
        .laser_hit(laser_hit),
        .ship_x(ship_x),
        .laser_top(laser_top),
        .laser_bot(laser_bot),
        .laser_left(laser_left),
        .laser_right(laser_right),
        .ship_on(ship_on),
        .laser_on(laser_on)
    );

    typedef struct {
        string      name;
        logic [9:0] ship;
        logic [9:0] top;
        logic [9:0] bot;
        logic [9:0] left;
        logic [9:0] right;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        string      name;
        logic       l;
        logic       r;
        int         n;
        logic [9:0] ship;
    } mv_t;

    typedef struct {
        string      name;
        logic [9:0] px;
        logic [9:0] py;
        logic       s_on;
        logic       l_on;
    } pix_t;

    function automatic mv_t mk_mv(string name, logic l, logic r, int n, logic [9:0] ship);
        mv_t m;
        m.name = name; m.l = l; m.r = r; m.n = n; m.ship = ship;
        return m;
    endfunction

    function automatic pix_t mk_pix(string name, logic [9:0] px, logic [9:0] py, logic s_on, logic l_on);
        pix_t p;
        p.name = name; p.px = px; p.py = py; p.s_on = s_on; p.l_on = l_on;
        return p;
    endfunction

    task automatic expect_out(string name, logic [9:0] ship, bit fly, logic [9:0] top, logic [9:0] left);
        exp_t e;
        e.name = name;
        e.ship = ship;
        if (fly) begin
            e.top = top; e.bot = top + 10'd11; e.left = left; e.right = left + 10'd3;
        end else begin
            e.top = 10'd1023; e.bot = 10'd1023; e.left = 10'd1023; e.right = 10'd1023;
        end
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: no expected record");
            return;
        end
        e = exp_q.pop_front();
        if ({ship_x, laser_top, laser_bot, laser_left, laser_right} !==
            {e.ship, e.top, e.bot, e.left, e.right}) begin
            bad++;
            $display("FAIL %s: got ship=%0d top=%0d bot=%0d left=%0d right=%0d want ship=%0d top=%0d bot=%0d left=%0d right=%0d",
                     e.name, ship_x, laser_top, laser_bot, laser_left, laser_right,
                     e.ship, e.top, e.bot, e.left, e.right);
        end
    endtask

    // One frame tick (optionally with a coincident laser_hit), sampled at the
    // following falling edge.
    task automatic frame(input logic hit);
        @(negedge clk);
        x = 10'd0; y = 10'd481; laser_hit = hit;
        @(negedge clk);
        x = 10'd700; y = 10'd0; laser_hit = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic tick_chk(string name, logic [9:0] ship, bit fly, logic [9:0] top, logic [9:0] left);
        expect_out(name, ship, fly, top, left);
        frame(1'b0);
        compare_out();
    endtask

    task automatic now_chk(string name, logic [9:0] ship, bit fly, logic [9:0] top, logic [9:0] left);
        expect_out(name, ship, fly, top, left);
        compare_out();
    endtask

    task automatic set_btn(input logic l, input logic r);
        @(negedge clk);
        btn_left = l; btn_right = r;
        repeat (3) @(negedge clk);
    endtask

    task automatic fire_edge();
        @(negedge clk);
        btn_fire = 1'b1;
        repeat (4) @(negedge clk);
        btn_fire = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        laser_hit = 1'b1;
        @(negedge clk);
        laser_hit = 1'b0;
    endtask

    task automatic pix_chk(pix_t p);
        @(negedge clk);
        x = p.px; y = p.py;
        #1;
        total++;
        if (ship_on !== p.s_on || laser_on !== p.l_on) begin
            bad++;
            $display("FAIL %s: got ship_on=%0b laser_on=%0b want ship_on=%0b laser_on=%0b",
                     p.name, ship_on, laser_on, p.s_on, p.l_on);
        end
        x = 10'd700; y = 10'd0;
    endtask

    mv_t  mv[9];
    pix_t px_ship[6];
    pix_t px_laser[5];

    initial begin
        mv[0] = mk_mv("right10",    1'b0, 1'b1, 10,  10'd320);
        mv[1] = mk_mv("left5",      1'b1, 1'b0, 5,   10'd310);
        mv[2] = mk_mv("both_hold",  1'b1, 1'b1, 3,   10'd310);
        mv[3] = mk_mv("none_hold",  1'b0, 1'b0, 3,   10'd310);
        mv[4] = mk_mv("right_to600",1'b0, 1'b1, 145, 10'd600);
        mv[5] = mk_mv("right_edge", 1'b0, 1'b1, 4,   10'd600);
        mv[6] = mk_mv("left_to0",   1'b1, 1'b0, 300, 10'd0);
        mv[7] = mk_mv("left_edge",  1'b1, 1'b0, 2,   10'd0);
        mv[8] = mk_mv("right_to300",1'b0, 1'b1, 150, 10'd300);

        px_ship[0] = mk_pix("ship_tl",    10'd300, 10'd450, 1'b1, 1'b0);
        px_ship[1] = mk_pix("ship_br",    10'd339, 10'd459, 1'b1, 1'b0);
        px_ship[2] = mk_pix("ship_rout",  10'd340, 10'd455, 1'b0, 1'b0);
        px_ship[3] = mk_pix("ship_lout",  10'd299, 10'd455, 1'b0, 1'b0);
        px_ship[4] = mk_pix("ship_below", 10'd320, 10'd460, 1'b0, 1'b0);
        px_ship[5] = mk_pix("ship_above", 10'd320, 10'd449, 1'b0, 1'b0);

        px_laser[0] = mk_pix("laser_tl",   10'd318, 10'd418, 1'b0, 1'b1);
        px_laser[1] = mk_pix("laser_br",   10'd321, 10'd429, 1'b0, 1'b1);
        px_laser[2] = mk_pix("laser_rout", 10'd322, 10'd420, 1'b0, 1'b0);
        px_laser[3] = mk_pix("laser_bout", 10'd318, 10'd430, 1'b0, 1'b0);
        px_laser[4] = mk_pix("laser_lout", 10'd317, 10'd420, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        now_chk("reset", 10'd300, 1'b0, 10'd0, 10'd0);
        @(negedge clk);
        reset = 1'b0;

        // Ship movement table
        for (int i = 0; i < 9; i++) begin
            set_btn(mv[i].l, mv[i].r);
            tick_n(mv[i].n - 1);
            tick_chk(mv[i].name, mv[i].ship, 1'b0, 10'd0, 10'd0);
        end

        // Near-miss coordinates must not act as a frame tick
        @(negedge clk); x = 10'd1; y = 10'd481;
        @(negedge clk); x = 10'd0; y = 10'd480;
        @(negedge clk); x = 10'd700; y = 10'd0;
        now_chk("near_miss", 10'd300, 1'b0, 10'd0, 10'd0);
        set_btn(1'b0, 1'b0);

        for (int i = 0; i < 6; i++) pix_chk(px_ship[i]);

        // Launch and flight
        fire_edge();
        now_chk("pending_no_tick", 10'd300, 1'b0, 10'd0, 10'd0);
        tick_chk("launch", 10'd300, 1'b1, 10'd438, 10'd318);
        tick_n(4);
        tick_chk("fly5", 10'd300, 1'b1, 10'd418, 10'd318);
        for (int i = 0; i < 5; i++) pix_chk(px_laser[i]);

        // Hit coincident with tick, fire pressed during cooldown
        expect_out("hit_tick", 10'd300, 1'b0, 10'd0, 10'd0);
        frame(1'b1);
        compare_out();
        fire_edge();
        for (int i = 0; i < 8; i++) tick_chk("cooldown", 10'd300, 1'b0, 10'd0, 10'd0);
        tick_chk("launch_after_cool", 10'd300, 1'b1, 10'd438, 10'd318);

        // Unhit flight to the top
        tick_n(108);
        tick_chk("top2", 10'd300, 1'b1, 10'd2, 10'd318);
        tick_chk("exhaust", 10'd300, 1'b0, 10'd0, 10'd0);

        // Launch column uses pre-move ship_x
        set_btn(1'b0, 1'b1);
        fire_edge();
        tick_n(7);
        tick_chk("ride_cool8", 10'd316, 1'b0, 10'd0, 10'd0);
        tick_chk("launch_premove", 10'd318, 1'b1, 10'd438, 10'd334);
        set_btn(1'b0, 1'b0);
        pix_chk(mk_pix("laser_live", 10'd334, 10'd438, 1'b0, 1'b1));
        pix_chk(mk_pix("ship_moved", 10'd318, 10'd450, 1'b1, 1'b0));

        // Reset mid-flight removes the laser without waiting for a clock
        @(negedge clk);
        x = 10'd334; y = 10'd438;
        #1 reset = 1'b1;
        #1;
        now_chk("reset_mid", 10'd300, 1'b0, 10'd0, 10'd0);
        total++;
        if (laser_on !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_laser_on: got %0b want 0", laser_on);
        end
        @(negedge clk);
        reset = 1'b0; x = 10'd700; y = 10'd0;

        // Hit outside flight is ignored; pending fire still launches
        fire_edge();
        hit_pulse();
        now_chk("idle_hit_ignored", 10'd300, 1'b0, 10'd0, 10'd0);
        tick_chk("relaunch", 10'd300, 1'b1, 10'd438, 10'd318);

        // Held fire: one launch by default, continuous relaunch with autofire
        hit_pulse();
        now_chk("hit_no_tick", 10'd300, 1'b0, 10'd0, 10'd0);
        @(negedge clk);
        btn_fire = 1'b1;
        repeat (4) @(negedge clk);
        tick_n(7);
        tick_chk("held_cool8", 10'd300, 1'b0, 10'd0, 10'd0);
        tick_chk("held_launch", 10'd300, 1'b1, 10'd438, 10'd318);
        hit_pulse();
        tick_n(8);
`ifdef LASER_AUTOFIRE_EN
        tick_chk("held_relaunch", 10'd300, 1'b1, 10'd438, 10'd318);
`else
        tick_chk("held_no_relaunch", 10'd300, 1'b0, 10'd0, 10'd0);
`endif
        btn_fire = 1'b0;

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d records want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ship_laser_gen.md
SHIP_LASER_GEN -- requirements
Module: ship_laser_gen

Interface
REQ-001 SHALL have parameter SHIP_Y_TOP, default 450, ship top row.
REQ-002 SHALL have parameter SHIP_W, default 40, ship width in pixels.
REQ-003 SHALL have parameter SHIP_H, default 10, ship height in pixels.
REQ-004 SHALL have parameter LASER_W, default 4, laser width.
REQ-005 SHALL have parameter LASER_H, default 12, laser height.
REQ-006 SHALL have parameter LASER_SPEED, default 4, pixels moved up per frame.
REQ-007 SHALL have parameter SHIP_SPEED, default 2, pixels moved sideways per frame.
REQ-008 SHALL have parameter COOLDOWN_FRAMES, default 8, frames between laser end and next launch.
REQ-009 SHALL have port clk, input, 1, system clock.
REQ-010 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-011 SHALL have ports x and y, input, 10 each, current pixel column and row.
REQ-012 SHALL have ports btn_left, btn_right and btn_fire, input, 1 each, raw asynchronous buttons.
REQ-013 SHALL have port laser_hit, input, 1, collision report from the alien stage.
REQ-014 SHALL have port ship_x, output, 10, ship left column.
REQ-015 SHALL have ports laser_top, laser_bot, laser_left and laser_right, output, 10 each, laser bounds.
REQ-016 SHALL have ports ship_on and laser_on, output, 1 each, pixel-inside flags.

Function
REQ-017 SHALL synchronise each button through two flops before use.
REQ-018 SHALL generate a frame tick for one cycle when y==481 and x==0.
- This is the only event that moves the ship or the laser.
REQ-019 SHALL update ship_x on each frame tick as follows.
- Left only: subtract SHIP_SPEED when ship_x>=SHIP_SPEED, otherwise hold.
- Right only: add SHIP_SPEED when ship_x+SHIP_W-1+SHIP_SPEED<=639, otherwise hold.
- Both pressed or neither pressed: hold.
REQ-020 SHALL latch fire_pending on a rising edge of the synchronised btn_fire.
- fire_pending clears on launch.
- Edges arriving outside IDLE stay pending.
REQ-021 SHALL implement a state machine with states IDLE, FLY and COOLDOWN.
REQ-022 SHALL move IDLE->FLY on a frame tick while fire_pending=1.
- On launch: laser_left=ship_x+(SHIP_W-LASER_W)/2 and laser_top=SHIP_Y_TOP-LASER_H.
- The launch position uses the ship_x value from before that tick's ship move.
REQ-023 SHALL, in FLY, move the laser on each frame tick.
- laser_top decrements by LASER_SPEED.
- When laser_top<LASER_SPEED, go to COOLDOWN instead of decrementing.
REQ-024 SHALL go FLY->COOLDOWN on the next clock edge whenever laser_hit=1 in FLY.
- laser_hit has priority over a simultaneous frame tick.
- laser_hit is ignored outside FLY.
REQ-025 SHALL load an internal frame counter with COOLDOWN_FRAMES on entry to COOLDOWN.
- The counter decrements on each frame tick.
- COOLDOWN->IDLE on the tick at which the counter equals 1.
REQ-026 SHALL drive laser bounds as follows.
- laser_bot=laser_top+LASER_H-1 and laser_right=laser_left+LASER_W-1 in FLY.
- In IDLE and COOLDOWN, park all four bounds at 1023 so that no collision is possible.
REQ-027 SHALL compute ship_on and laser_on combinationally from x, y and the current registers.
- laser_on is 0 outside FLY.
- ship_on spans rows SHIP_Y_TOP to SHIP_Y_TOP+SHIP_H-1 and columns ship_x to ship_x+SHIP_W-1.
REQ-028 SHALL perform all arithmetic in 10 bits.
- The guards in REQ-019 and REQ-023 prevent any wrap-around.

Reset
REQ-029 SHALL, on reset, force the following values.
- State IDLE, ship_x=300, fire_pending=0, cooldown counter=0.
- Laser bounds 1023, synchroniser flops 0.
REQ-030 SHALL, on reset asserted mid-flight, remove the laser immediately.
- A fire edge after reset release needs a full re-synchronisation before it is recognised.

Configuration
REQ-031 SHALL support macro LASER_AUTOFIRE_EN.
- Defined: a held btn_fire (synchronised level 1) sets fire_pending every frame tick, giving continuous relaunch after each cooldown.
- Undefined: only rising edges set fire_pending.

Verification
REQ-032 SHALL cover these directed scenarios.
- Reset, then hold btn_right for 10 frames: ship_x 300->320; hold at ship_x=600 -> stays 600.
- Fire edge with ship_x=300: next tick laser_left=318, laser_top=438, laser_bot=449; after 5 ticks laser_top=418.
- Pulse laser_hit 1 cycle in FLY, coincident with a frame tick: state COOLDOWN, bounds 1023, laser_top not decremented; IDLE after 8 ticks.
- Unhit laser: reaches laser_top=2 (438-109*4), next tick -> COOLDOWN without underflow.
- Fire pressed during COOLDOWN: launches on the first tick after IDLE; with LASER_AUTOFIRE_EN, held fire relaunches every flight+8 frames; reset mid-flight -> IDLE, ship_x=300.
